// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder sequencer.
// Accepts two N_DIGITS packed-BCD operands plus a carry-in. Adds one digit per
// clock, least-significant digit first. Returns an (N_DIGITS+1)-digit packed-BCD sum.
// Optional macro BCD_CTRL_DIGIT_CHECK_EN adds the err flag for non-BCD input nibbles.
// When the macro is undefined, err is tied low.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE. out_valid is high only in DONE.
// Both are decoded from the state register, so neither depends on in_valid or out_ready.
module bcd_serial_adder_ctrl #(
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] A,
    input  logic [4*N_DIGITS-1:0] B,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_DIGITS+3:0] S,
    output logic                  err,
    output logic [1:0]            state_dbg_o
);

    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [4*N_DIGITS-1:0]   a_q, a_d;
    logic [4*N_DIGITS-1:0]   b_q, b_d;
    logic                    carry_q, carry_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*N_DIGITS+3:0]   s_q, s_d;

    // One-digit BCD add stage; operand digits sit in the low nibble of the shift registers.
    logic [4:0] dig_t;
    logic [4:0] dig_t6;
    logic [3:0] dig_val;
    logic       dig_carry;

    assign dig_t     = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign dig_t6    = dig_t + 5'd6;
    assign dig_carry = (dig_t > 5'd9);
    assign dig_val   = dig_carry ? dig_t6[3:0] : dig_t[3:0];

`ifdef BCD_CTRL_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic dig_bad;
    assign dig_bad = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign S           = s_q;
    assign state_dbg_o = state_q;

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
`ifdef BCD_CTRL_DIGIT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin;
                    cnt_d   = '0;
                    s_d     = '0;
`ifdef BCD_CTRL_DIGIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = dig_carry;
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[4*i +: 4] = dig_val;
                    end
                end
`ifdef BCD_CTRL_DIGIT_CHECK_EN
                if (dig_bad) begin
                    err_d = 1'b1;
                end
`endif
                if (cnt_q == LAST_CNT) begin
                    s_d[4*N_DIGITS +: 4] = {3'b000, dig_carry};
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

`ifdef BCD_CTRL_DIGIT_CHECK_EN
    // Sticky non-BCD-digit flag, cleared on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl with N_DIGITS = 3.
module tb_bcd_serial_adder_ctrl;

  localparam int N  = 3;
  localparam int AW = 4 * N;
  localparam int SW = 4 * N + 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a_in;
  logic [AW-1:0] b_in;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] s_out;
  logic          err;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] exp_q[$];
  logic          exp_err_q[$];

  bcd_serial_adder_ctrl #(.N_DIGITS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (a_in),
    .B           (b_in),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .S           (s_out),
    .err         (err),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit all_legal(input logic [AW-1:0] v);
    for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [AW-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [SW-1:0] model_sum(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic c);
    logic [SW-1:0] r = '0;
    if (all_legal(a) && all_legal(b)) begin
      // Legal operands: plain decimal addition, converted back to BCD.
      int total = bcd_to_int(a) + bcd_to_int(b) + int'(c);
      for (int i = 0; i <= N; i++) begin
        r[4*i +: 4] = 4'(total % 10);
        total = total / 10;
      end
    end else begin
      // Illegal digits: apply the per-digit rule t>9 -> (t+6) mod 16, carry 1.
      int cy = int'(c);
      for (int i = 0; i < N; i++) begin
        int t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
        if (t > 9) begin r[4*i +: 4] = 4'((t + 6) % 16); cy = 1; end
        else       begin r[4*i +: 4] = 4'(t);            cy = 0; end
      end
      r[4*N +: 4] = 4'(cy);
    end
    return r;
  endfunction

  function automatic logic model_err(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef BCD_CTRL_DIGIT_CHECK_EN
    return !(all_legal(a) && all_legal(b));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one operation at a negedge and completes acceptance at the next posedge.
  // On return, the time is #1 after the acceptance edge. The expectation is queued.
  task automatic send_op(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, in_ready);
    end
    exp_q.push_back(model_sum(a, b, c));
    exp_err_q.push_back(model_err(a, b));
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_after_accept got=%b want=0", name, in_ready);
    end
  endtask

  // Waits (bounded) for out_valid and checks the latency, S and err against the scoreboard.
  // The result is not released here.
  task automatic wait_result(input string name);
    int cyc = 0;
    logic [SW-1:0] es;
    logic          ee;
    while (out_valid !== 1'b1 && cyc < N + 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    es = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    checks++;
    if (cyc != N) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, cyc, N);
    end
    checks++;
    if (s_out !== es) begin
      failures++;
      $display("FAIL %s sum got=%h want=%h", name, s_out, es);
    end
    checks++;
    if (err !== ee) begin
      failures++;
      $display("FAIL %s err got=%b want=%b", name, err, ee);
    end
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got=v%b r%b want=v0 r1", name, out_valid, in_ready);
    end
  endtask

  task automatic run_op(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic c);
    send_op(name, a, b, c);
    in_valid = 1'b0;
    wait_result(name);
    release_result(name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s_out !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset got=r%b v%b s%h e%b want=r1 v0 s0000 e0", in_ready, out_valid, s_out, err);
    end
  endtask

  task automatic test_directed();
    run_op("d_053_011", 12'h053, 12'h011, 1'b0);
    run_op("d_999_001", 12'h999, 12'h001, 1'b0);
    run_op("d_999_999_c", 12'h999, 12'h999, 1'b1);
    run_op("d_000_000", 12'h000, 12'h000, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [AW-1:0] a, b;
      for (int i = 0; i < N; i++) begin
        a[4*i +: 4] = 4'($urandom_range(0, 9));
        b[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_op("rand", a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    send_op("bp", 12'h500, 12'h500, 1'b0);
    in_valid = 1'b0;
    wait_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || s_out !== 16'h1000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=v%b s%h r%b want=v1 s1000 r0", i, out_valid, s_out, in_ready);
      end
    end
    release_result("bp");
  endtask

  task automatic test_reset_mid_run();
    send_op("rst_mid", 12'h123, 12'h456, 1'b0);
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_err_q.pop_back());
    @(posedge clk); #1;  // digit 0 processed
    @(posedge clk); #1;  // digit 1 processed
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s_out !== '0 || in_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got=v%b s%h r%b e%b want=v0 s0000 r1 e0", out_valid, s_out, in_ready, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The discarded operation must never surface.
    repeat (N + 2) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_ghost got=%b want=0", out_valid);
      end
    end
    run_op("rst_after", 12'h123, 12'h456, 1'b0);
    checks++;
    if (s_out !== 16'h0579) begin
      failures++;
      $display("FAIL rst_after_held got=%h want=0579", s_out);
    end
  endtask

  task automatic test_digit_check();
    run_op("bad_0A5", 12'h0A5, 12'h001, 1'b0);
    run_op("bad_F9F", 12'hF9F, 12'h0B0, 1'b1);
    run_op("clear_after_bad", 12'h321, 12'h111, 1'b0);
  endtask

  task automatic test_hold_valid();
    int n_results = 0;
    send_op("hold", 12'h246, 12'h135, 1'b0);
    // Keep requesting with different operands; these must be ignored.
    a_in = 12'h999; b_in = 12'h999; cin = 1'b1;
    wait_result("hold");
    n_results = 1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || s_out !== 16'h0381) begin
        failures++;
        $display("FAIL hold_stable got=r%b s%h want=r0 s0381", in_ready, s_out);
      end
    end
    // Release with in_valid still high: IDLE first, acceptance only on the next edge.
    @(negedge clk);
    out_ready = 1'b1;
    exp_q.push_back(model_sum(12'h999, 12'h999, 1'b1));
    exp_err_q.push_back(model_err(12'h999, 12'h999));
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle got=v%b r%b want=v0 r1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept got=r%b want=r0", in_ready);
    end
    wait_result("b2b");
    n_results++;
    release_result("b2b");
    checks++;
    if (n_results != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL hold_count got=%0d/%0d want=2/0", n_results, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_digit_check();
    test_hold_valid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
